// File: rtl/peak_counter_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// peak_counter_cmd_decoder_pkg
// Shared definitions for the command decoder and its timeout timer:
//   - frame constants (default SYNC byte, opcode values)
//   - FSM state encoding and the decoded-command struct
//   - helpers: clog2, opcode validity check, opcode-to-command decode
// -----------------------------------------------------------------------------
package peak_counter_cmd_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] OPC_START         = 8'h01;
    localparam logic [7:0] OPC_STOP          = 8'h02;
    localparam logic [7:0] OPC_GET_RST       = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPC   = 2'd1,
        ST_CHK   = 2'd2,
        ST_ISSUE = 2'd3
    } state_e;

    typedef struct packed {
        logic start;
        logic get_rst;
    } cmd_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 32'd0;
        rem    = value - 32'd1;
        while (rem > 32'd0) begin
            result = result + 32'd1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic logic opcode_valid(input logic [7:0] opc);
        logic ok;
        case (opc)
            OPC_START, OPC_STOP, OPC_GET_RST: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // GET_RST keeps start=1 so counting resumes after the readout.
    function automatic cmd_t decode_opcode(input logic [7:0] opc);
        cmd_t cmd;
        case (opc)
            OPC_START: begin
                cmd.start   = 1'b1;
                cmd.get_rst = 1'b0;
            end
            OPC_GET_RST: begin
                cmd.start   = 1'b1;
                cmd.get_rst = 1'b1;
            end
            default: begin
                cmd.start   = 1'b0;
                cmd.get_rst = 1'b0;
            end
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/peak_counter_cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// peak_counter_cmd_decoder_if
// Byte-in / command-out bus of the decoder.
//   rx_data_in/rx_vld_in/rx_rdy_out    : byte stream from the host FIFO
//   cmd_vld_out/cmd_start_out/
//   cmd_get_rst_out/cmd_rdy_in         : command handshake to the controller
//   err_out/err_count_out              : rejected-frame diagnostics
// master = host/controller side, slave = decoder.
// -----------------------------------------------------------------------------
interface peak_counter_cmd_decoder_if #(
    parameter int ERR_CNT_WIDTH = 8
);
    logic [7:0]               rx_data_in;
    logic                     rx_vld_in;
    logic                     rx_rdy_out;
    logic                     cmd_vld_out;
    logic                     cmd_start_out;
    logic                     cmd_get_rst_out;
    logic                     cmd_rdy_in;
    logic                     err_out;
    logic [ERR_CNT_WIDTH-1:0] err_count_out;

    modport master (
        output rx_data_in, rx_vld_in, cmd_rdy_in,
        input  rx_rdy_out, cmd_vld_out, cmd_start_out, cmd_get_rst_out,
               err_out, err_count_out
    );

    modport slave (
        input  rx_data_in, rx_vld_in, cmd_rdy_in,
        output rx_rdy_out, cmd_vld_out, cmd_start_out, cmd_get_rst_out,
               err_out, err_count_out
    );
endinterface

// File: rtl/peak_counter_timeout_timer.sv
// -----------------------------------------------------------------------------
// peak_counter_timeout_timer
// Idle-cycle counter for in-frame byte gaps.
//   clk, rst : clock, async active-high reset
//   clear    : restart counting from zero (takes priority over expiry)
//   enable   : count while high
//   expired  : high on the cycle the count sits at TIMEOUT_CYCLES-1 while
//              enabled and not cleared
// -----------------------------------------------------------------------------
module peak_counter_timeout_timer
    import peak_counter_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 48000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned TO_WIDTH = clog2(TIMEOUT_CYCLES);
    localparam logic [TO_WIDTH-1:0] LAST_COUNT = TO_WIDTH'(TIMEOUT_CYCLES - 32'd1);

    logic [TO_WIDTH-1:0] count_q;
    logic [TO_WIDTH-1:0] count_d;

    // Next count: clear wins, then increment, parking at the last value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {TO_WIDTH{1'b0}};
        end else if (enable && (count_q != LAST_COUNT)) begin
            count_d = count_q + TO_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {TO_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // A byte arriving on the last cycle raises clear, so it beats the timeout.
    assign expired = enable && !clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/peak_counter_cmd_decoder.sv
// -----------------------------------------------------------------------------
// peak_counter_cmd_decoder
// Validates 3-byte frames SYNC, OPCODE, ~OPCODE from the host byte stream and
// issues START / STOP / GET_RST commands to the controller over valid/ready.
// Malformed and timed-out frames pulse err_out and bump a saturating counter.
//   clk, rst : clock, async active-high reset
//   bus      : peak_counter_cmd_decoder_if slave modport (byte in, command
//              out, error diagnostics); all bus outputs are registered
// -----------------------------------------------------------------------------
module peak_counter_cmd_decoder
    import peak_counter_cmd_decoder_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 48000,
    parameter int          ERR_CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    peak_counter_cmd_decoder_if.slave   bus
);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    state_e                   state_q,       state_d;
    logic [7:0]               opcode_q,      opcode_d;
    logic                     rx_rdy_q,      rx_rdy_d;
    logic                     cmd_vld_q,     cmd_vld_d;
    logic                     cmd_start_q,   cmd_start_d;
    logic                     cmd_get_rst_q, cmd_get_rst_d;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q,   err_count_d;

    logic rx_fire_s;
    logic err_s;
    logic timer_en_s;
    logic timer_clear_s;
    logic timeout_s;
    cmd_t decoded_s;

    assign rx_fire_s     = bus.rx_vld_in && rx_rdy_q;
    assign timer_en_s    = (state_q == ST_OPC) || (state_q == ST_CHK);
    // Clearing outside OPC/CHK guarantees a zero count on entry.
    assign timer_clear_s = rx_fire_s || !timer_en_s;

    peak_counter_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timeout_s)
    );

    // Frame FSM next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        cmd_start_d   = cmd_start_q;
        cmd_get_rst_d = cmd_get_rst_q;
        err_s         = 1'b0;
        decoded_s     = decode_opcode(opcode_q);

        case (state_q)
            ST_IDLE: begin
                if (rx_fire_s && (bus.rx_data_in == SYNC_BYTE)) begin
                    state_d = ST_OPC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPC: begin
                // Any byte is taken as the opcode, even a repeated SYNC.
                if (rx_fire_s) begin
                    opcode_d = bus.rx_data_in;
                    state_d  = ST_CHK;
                end else if (timeout_s) begin
                    err_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPC;
                end
            end
            ST_CHK: begin
                if (rx_fire_s) begin
                    if (opcode_valid(opcode_q) && (bus.rx_data_in == ~opcode_q)) begin
                        cmd_start_d   = decoded_s.start;
                        cmd_get_rst_d = decoded_s.get_rst;
                        state_d       = ST_ISSUE;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    err_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_ISSUE: begin
                if (cmd_vld_q && bus.cmd_rdy_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The first ISSUE cycle only raises valid, giving the one-cycle
        // decode-to-valid latency; valid drops with the handshake.
        cmd_vld_d = (state_q == ST_ISSUE) && (state_d == ST_ISSUE);
        rx_rdy_d  = (state_d != ST_ISSUE);

        if (err_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            opcode_q      <= 8'h00;
            rx_rdy_q      <= 1'b0;
            cmd_vld_q     <= 1'b0;
            cmd_start_q   <= 1'b0;
            cmd_get_rst_q <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            rx_rdy_q      <= rx_rdy_d;
            cmd_vld_q     <= cmd_vld_d;
            cmd_start_q   <= cmd_start_d;
            cmd_get_rst_q <= cmd_get_rst_d;
            err_q         <= err_s;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.rx_rdy_out      = rx_rdy_q;
    assign bus.cmd_vld_out     = cmd_vld_q;
    assign bus.cmd_start_out   = cmd_start_q;
    assign bus.cmd_get_rst_out = cmd_get_rst_q;
    assign bus.err_out         = err_q;
    assign bus.err_count_out   = err_count_q;

endmodule

// File: tb/tb_peak_counter_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_peak_counter_cmd_decoder
// Scoreboard bench: the driver feeds bytes, a frame-level reference model
// pushes expected commands / error counts, and a negedge monitor compares
// whatever the decoder presents.
// -----------------------------------------------------------------------------
module tb_peak_counter_cmd_decoder;
    localparam int         TO      = 16;
    localparam int         ERR_MAX = 255;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef struct {
        bit start;
        bit get_rst;
        int acc;
    } exp_cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

    exp_cmd_t   exp_cmd[$];
    int         exp_err[$];
    int         obs_err[$];
    logic [7:0] frm[$];
    int         last_acc = -1000;
    int         err_n = 0;
    bit         vld_prev = 1'b0;

    peak_counter_cmd_decoder_if #(.ERR_CNT_WIDTH(8)) bus ();

    peak_counter_cmd_decoder #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO),
        .ERR_CNT_WIDTH  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Controller-side ready, changed just after the edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.cmd_rdy_in = 1'b1;
            1:       bus.cmd_rdy_in = 1'b0;
            default: bus.cmd_rdy_in = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model (frame level) ----------------
    task automatic model_err();
        err_n++;
        exp_err.push_back((err_n > ERR_MAX) ? ERR_MAX : err_n);
    endtask

    // A partial frame is dropped once TO cycles have passed without a byte.
    task automatic model_flush(input int now_edge);
        if (frm.size() > 0 && now_edge >= last_acc + TO) begin
            model_err();
            frm.delete();
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input int acc_edge);
        logic [7:0] opc;
        model_flush(acc_edge - 1);
        last_acc = acc_edge;
        if (frm.size() == 0) begin
            if (b == SYNC) frm.push_back(b);
        end else if (frm.size() == 1) begin
            frm.push_back(b);
        end else begin
            opc = frm[1];
            if ((opc == 8'h01 || opc == 8'h02 || opc == 8'h03) && b == ~opc)
                exp_cmd.push_back('{opc != 8'h02, opc == 8'h03, acc_edge});
            else
                model_err();
            frm.delete();
        end
    endtask

    task automatic model_reset();
        frm.delete();
        exp_cmd.delete();
        exp_err.delete();
        obs_err.delete();
        err_n = 0;
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input int idle);
        bit done;
        done = 1'b0;
        repeat (idle) @(negedge clk);
        bus.rx_data_in = b;
        bus.rx_vld_in  = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            if (bus.rx_rdy_out === 1'b1) begin
                @(negedge clk);
                done = 1'b1;
                model_accept(b, cyc);
            end else begin
                @(negedge clk);
            end
        end
        bus.rx_vld_in = 1'b0;
        if (!done) fail_now("rx_accept_timeout");
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_vld_out === 1'b1) ok = 1'b1;
        end
        if (!ok) fail_now("cmd_vld_wait_timeout");
    endtask

    task automatic drain();
        repeat (TO + 6) @(negedge clk);
        model_flush(cyc);
        repeat (3) @(negedge clk);
        check("pending_cmds", exp_cmd.size(), 0);
        check("err_events_balance", obs_err.size(), exp_err.size());
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_rdy", bus.rx_rdy_out, 0);
        check("rst_cmd_vld", bus.cmd_vld_out, 0);
        check("rst_cmd_start", bus.cmd_start_out, 0);
        check("rst_cmd_get_rst", bus.cmd_get_rst_out, 0);
        check("rst_err", bus.err_out, 0);
        check("rst_err_count", bus.err_count_out, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 1'b0;
        end else begin
            if (bus.err_out === 1'b1) obs_err.push_back(int'(bus.err_count_out));
            while (obs_err.size() > 0 && exp_err.size() > 0)
                check("err_count_on_pulse", obs_err.pop_front(), exp_err.pop_front());
            if (bus.cmd_vld_out === 1'b1) begin
                check("rx_rdy_low_in_issue", bus.rx_rdy_out, 0);
                if (exp_cmd.size() == 0) begin
                    fail_now("unexpected_cmd_vld");
                end else begin
                    if (!vld_prev) check("cmd_latency", cyc, exp_cmd[0].acc + 1);
                    check("cmd_start", bus.cmd_start_out, exp_cmd[0].start);
                    check("cmd_get_rst", bus.cmd_get_rst_out, exp_cmd[0].get_rst);
                    if (bus.cmd_rdy_in === 1'b1) void'(exp_cmd.pop_front());
                end
            end
            vld_prev = (bus.cmd_vld_out === 1'b1) && (bus.cmd_rdy_in !== 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit         ok;
        int         kind;
        logic [7:0] opc;
        logic [7:0] chk;

        bus.rx_data_in = 8'h00;
        bus.rx_vld_in  = 1'b0;
        bus.cmd_rdy_in = 1'b0;

        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rx_rdy_after_reset", bus.rx_rdy_out, 1);

        // START with ready high: one-cycle valid.
        rdy_mode = 0;
        send_frame(8'hA5, 8'h01, 8'hFE);
        drain();
        check("err_count_after_start", bus.err_count_out, 0);

        // GET_RST held pending for 10 cycles while another byte is offered.
        rdy_mode = 1;
        fork
            begin
                send_frame(8'hA5, 8'h03, 8'hFC);
                send_frame(8'hA5, 8'h02, 8'hFD);
            end
            begin
                wait_vld(ok);
                for (int i = 0; i < 10; i++) begin
                    check("hold_vld", bus.cmd_vld_out, 1);
                    check("hold_rx_rdy", bus.rx_rdy_out, 0);
                    check("hold_start", bus.cmd_start_out, 1);
                    check("hold_get_rst", bus.cmd_get_rst_out, 1);
                    @(negedge clk);
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Leading garbage, then STOP.
        send_byte(8'h00, 0);
        send_byte(8'h37, 0);
        send_frame(8'hA5, 8'h02, 8'hFD);
        drain();

        // Bad check, then invalid opcode.
        send_frame(8'hA5, 8'h02, 8'h00);
        send_frame(8'hA5, 8'h07, 8'hF8);
        drain();
        check("err_count_two_bad", bus.err_count_out, 2);

        // Timeout after SYNC, then a good frame; then a byte on the last cycle.
        send_byte(8'hA5, 0);
        send_byte(8'hA5, TO);
        send_byte(8'h01, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h02, TO - 1);
        send_byte(8'hFD, TO - 1);
        drain();
        check("err_count_after_timeout", bus.err_count_out, 3);

        // Randomized frames with random ready.
        rdy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            opc  = 8'($urandom_range(1, 3));
            chk  = ~opc;
            case (kind)
                2: chk = ~opc ^ (8'h01 << $urandom_range(0, 7));
                3: begin
                    opc = 8'($urandom_range(4, 255));
                    chk = ~opc;
                end
                4: send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                default: ;
            endcase
            send_byte(SYNC, $urandom_range(0, 2));
            if (kind == 5) begin
                case ($urandom_range(0, 2))
                    0:       send_byte(opc, TO - 1);
                    1:       send_byte(opc, TO);
                    default: send_byte(opc, TO + 3);
                endcase
            end else begin
                send_byte(opc, $urandom_range(0, 2));
            end
            send_byte(chk, $urandom_range(0, 2));
        end
        rdy_mode = 0;
        drain();

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) send_frame(8'hA5, 8'h07, 8'hF8);
        drain();
        check("err_count_saturated", bus.err_count_out, ERR_MAX);

        // Reset while a command is pending.
        rdy_mode = 1;
        send_frame(8'hA5, 8'h01, 8'hFE);
        wait_vld(ok);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_vld_after_reset", bus.cmd_vld_out, 0);
        end
        send_frame(8'hA5, 8'h03, 8'hFC);
        drain();
        check("err_count_after_midreset", bus.err_count_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
